bin_to_bcd_dd: RTL and testbench
================================

BIN_TO_BCD_DD -- requirements
Module: bin_to_bcd_dd

Interface
REQ-001 The block SHALL have parameter BIN_W, default 8, giving the binary input width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter BCD_DIGITS, default 3, giving the number of BCD output digits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_start, input, 1 bit: request to convert i_binary; sampled only in IDLE.
REQ-006 The block SHALL have port i_binary, input, BIN_W bits: the value to convert, captured on the accepting edge.
REQ-007 The block SHALL have port o_busy, output, 1 bit: high while a conversion is in progress, including the DONE cycle.
REQ-008 The block SHALL have port o_bcd, output, 4*BCD_DIGITS bits: the packed BCD result, with the least-significant digit in bits [3:0].
REQ-009 The block SHALL have port o_dv, output, 1 bit: a one-cycle pulse marking that o_bcd has just been updated.
REQ-010 The block SHALL have port o_sign, output, 1 bit: sign of the converted value (see Configuration).

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, ADD3, SHIFT and DONE.
REQ-012 In IDLE with i_start=1 at edge T, the block SHALL load i_binary into the shift register, clear the BCD digits, set the bit counter to BIN_W, and go to ADD3.
REQ-013 In ADD3, every BCD digit >=5 SHALL have 3 added in parallel in one cycle, then the FSM SHALL go to SHIFT.
REQ-014 In SHIFT, the combined {digits, binary} register SHALL shift left 1 and the counter SHALL decrement; if the counter reaches 0 the FSM SHALL go to DONE, else to ADD3.
REQ-015 In DONE, o_bcd SHALL be registered from the digits and o_dv SHALL pulse for exactly 1 cycle, after which the FSM SHALL return to IDLE.
REQ-016 Latency from the accepting edge T to o_dv high SHALL be exactly 2*BIN_W+1 cycles (o_dv high during cycle T+2*BIN_W+1).
REQ-017 o_busy SHALL be high from T+1 through the DONE cycle inclusive.
REQ-018 o_bcd and o_sign SHALL hold their last result until the next DONE.
REQ-019 i_start asserted while busy SHALL be ignored, with no queuing.
REQ-020 i_start held high continuously SHALL start a new conversion on the first IDLE cycle after DONE, so the minimum start-to-start spacing is 2*BIN_W+2 cycles.
REQ-021 A configuration with 10^BCD_DIGITS <= 2^BIN_W-1 is illegal, and elaboration/simulation SHALL report a fatal error.

Reset
REQ-022 On rst=1, the block SHALL asynchronously enter IDLE with o_busy=0, o_dv=0, o_bcd=0, o_sign=0, and the shift register and counter cleared.
REQ-023 On reset mid-conversion, the block SHALL abort the conversion, produce no o_dv pulse, and accept a new i_start on the first edge after rst deasserts.

Configuration
REQ-024 With macro BIN_TO_BCD_SIGNED_EN defined, i_binary SHALL be two's complement; at load, o_sign's pending value SHALL be i_binary[BIN_W-1], the converted magnitude SHALL be |i_binary| (treated as BIN_W-bit unsigned, so -2^(BIN_W-1) converts correctly), and latency SHALL be unchanged.
REQ-025 With BIN_TO_BCD_SIGNED_EN undefined, i_binary SHALL be unsigned and o_sign SHALL be tied to 0.

Structure
REQ-026 The FSM state enumeration, the add-3 threshold (5) and adjust constant (3), and a minimum-digits function of BIN_W SHALL reside in the shared package bin_to_bcd_pkg.
REQ-027 The per-digit conditional add-3 SHALL be implemented as combinational sub-module bcd_digit_adj (4-bit in, 4-bit out), instantiated BCD_DIGITS times.

Verification
REQ-028 Scenario: BIN_W=8, BCD_DIGITS=3, i_binary=255, pulse i_start -> o_dv 17 cycles later, o_bcd=0x255, o_busy high for 17 cycles.
REQ-029 Scenario: i_binary=0, then i_binary=99 -> o_bcd=0x000, then 0x099; o_bcd holds between the two results.
REQ-030 Scenario: i_start pulsed at cycle 5 of a conversion with a different i_binary -> ignored; the first result is unaffected and there is exactly one o_dv.
REQ-031 Scenario: rst asserted at cycle 8 of a conversion -> all outputs 0, no o_dv; a new start with 128 -> o_bcd=0x128.
REQ-032 Scenario: BIN_W=16, BCD_DIGITS=5, i_binary=65535 -> o_dv after 33 cycles, o_bcd=0x65535; with i_start held high, a second o_dv follows 34 cycles after the first.
REQ-033 Scenario: with BIN_TO_BCD_SIGNED_EN, BIN_W=8, i_binary=0x80 -> o_sign=1, o_bcd=0x128; i_binary=0x7F -> o_sign=0, o_bcd=0x127.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the binary-to-BCD double-dabble converter:
// FSM states, add-3 constants and the minimum-digit helper.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD3  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned ADJ_THRESH = 5;
  localparam int unsigned ADJ_CONST  = 3;

  // Decimal digits needed to represent 2^bin_w - 1.
  function automatic int min_digits(input int bin_w);
    longint unsigned v;
    int d;
    v = (64'd1 << bin_w) - 64'd1;
    d = 1;
    v = v / 64'd10;
    while (v != 64'd0) begin
      d = d + 1;
      v = v / 64'd10;
    end
    return d;
  endfunction

endpackage

// File: rtl/bin_to_bcd_dd_digit_adj.sv
// Combinational double-dabble correction for one BCD digit:
// adds 3 when the digit is 5 or more so the next shift carries correctly.
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'(ADJ_THRESH)) ? (i_digit + 4'(ADJ_CONST)) : i_digit;

endmodule

// File: rtl/bin_to_bcd_dd.sv
// Sequential double-dabble binary-to-BCD converter (one add-3 and one shift cycle per bit).
// Define BIN_TO_BCD_SIGNED_EN to treat i_binary as two's complement and report o_sign.
module bin_to_bcd_dd #(
  parameter int BIN_W      = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [BIN_W-1:0]        i_binary,
  output logic                    o_busy,
  output logic [4*BCD_DIGITS-1:0] o_bcd,
  output logic                    o_dv,
  output logic                    o_sign
);
  import bin_to_bcd_pkg::*;

  localparam int DIG_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
    $fatal(1, "bin_to_bcd_dd: BIN_W=%0d outside 4..32", BIN_W);
  end
  if (BCD_DIGITS < min_digits(BIN_W)) begin : g_bad_digits
    $fatal(1, "bin_to_bcd_dd: BCD_DIGITS=%0d too small for BIN_W=%0d", BCD_DIGITS, BIN_W);
  end

  state_t                   r_state;
  state_t                   w_next;
  logic [BIN_W-1:0]         r_bin;
  logic [DIG_W-1:0]         r_digits;
  logic [DIG_W-1:0]         r_bcd;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_sign;
  logic                     r_sign_pend;
  logic [DIG_W-1:0]         w_adj;
  logic [BIN_W-1:0]         w_load;
  logic                     w_load_sign;
  logic [DIG_W+BIN_W-1:0]   w_shifted;

`ifdef BIN_TO_BCD_SIGNED_EN
  // Magnitude kept as unsigned BIN_W bits, so the most negative value maps to 2^(BIN_W-1).
  assign w_load_sign = i_binary[BIN_W-1];
  assign w_load      = i_binary[BIN_W-1] ? (~i_binary + BIN_W'(1)) : i_binary;
`else
  assign w_load_sign = 1'b0;
  assign w_load      = i_binary;
`endif

  assign w_shifted = {r_digits, r_bin} << 1;

  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_digits[4*gi +: 4]),
      .o_digit (w_adj[4*gi +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_ADD3;
      S_ADD3:  w_next = S_SHIFT;
      S_SHIFT: w_next = (r_cnt == CNT_W'(1)) ? S_DONE : S_ADD3;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state != S_IDLE);
    o_dv   = (r_state == S_DONE);
  end

  // The result register is written on the last shift so it is already valid while o_dv is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin       <= '0;
      r_digits    <= '0;
      r_cnt       <= '0;
      r_bcd       <= '0;
      r_sign      <= 1'b0;
      r_sign_pend <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_bin       <= w_load;
            r_digits    <= '0;
            r_cnt       <= CNT_W'(BIN_W);
            r_sign_pend <= w_load_sign;
          end
        end
        S_ADD3: r_digits <= w_adj;
        S_SHIFT: begin
          {r_digits, r_bin} <= w_shifted;
          r_cnt             <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_bcd  <= w_shifted[BIN_W +: DIG_W];
            r_sign <= r_sign_pend;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_bcd  = r_bcd;
  assign o_sign = r_sign;

endmodule

// File: tb/tb_bin_to_bcd_dd.sv
// Directed bench for bin_to_bcd_dd: table of 8-bit vectors plus hand-written
// sequences for ignored start, mid-conversion reset and the 16-bit back-to-back case.
module tb_bin_to_bcd_dd;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic        busy8, dv8, sign8;
  logic [11:0] bcd8;

  logic        start16 = 1'b0;
  logic [15:0] bin16 = '0;
  logic        busy16, dv16, sign16;
  logic [19:0] bcd16;

  bin_to_bcd_dd #(.BIN_W(8), .BCD_DIGITS(3)) u_dut8 (
    .clk(clk), .rst(rst), .i_start(start8), .i_binary(bin8),
    .o_busy(busy8), .o_bcd(bcd8), .o_dv(dv8), .o_sign(sign8)
  );

  bin_to_bcd_dd #(.BIN_W(16), .BCD_DIGITS(5)) u_dut16 (
    .clk(clk), .rst(rst), .i_start(start16), .i_binary(bin16),
    .o_busy(busy16), .o_bcd(bcd16), .o_dv(dv16), .o_sign(sign16)
  );

`ifdef BIN_TO_BCD_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd_u;
    logic [11:0] bcd_s;
    logic        sign_s;
  } vec_t;

  vec_t vecs[11];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // lat is the cycle index (T+lat) in which o_dv is seen; 0 means it never came.
  task automatic conv8(input logic [7:0] b, output int lat, output int busy_n);
    @(negedge clk);
    bin8   = b;
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat    = 0;
    busy_n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy8) busy_n++;
      if (dv8) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  task automatic conv16(input logic [15:0] b, output int lat);
    @(negedge clk);
    bin16   = b;
    start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dv16) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bn, dv_n, gap;
    logic [11:0] exp8;
    logic        exps;

    vecs[0]  = '{8'd0,   12'h000, 12'h000, 1'b0};
    vecs[1]  = '{8'd99,  12'h099, 12'h099, 1'b0};
    vecs[2]  = '{8'd255, 12'h255, 12'h001, 1'b1};
    vecs[3]  = '{8'd128, 12'h128, 12'h128, 1'b1};
    vecs[4]  = '{8'd127, 12'h127, 12'h127, 1'b0};
    vecs[5]  = '{8'd1,   12'h001, 12'h001, 1'b0};
    vecs[6]  = '{8'd9,   12'h009, 12'h009, 1'b0};
    vecs[7]  = '{8'd10,  12'h010, 12'h010, 1'b0};
    vecs[8]  = '{8'd100, 12'h100, 12'h100, 1'b0};
    vecs[9]  = '{8'd200, 12'h200, 12'h056, 1'b1};
    vecs[10] = '{8'd59,  12'h059, 12'h059, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_dv8",   32'(dv8),   32'd0);
    check("rst_bcd8",  32'(bcd8),  32'd0);
    check("rst_sign8", 32'(sign8), 32'd0);
    check("rst_bcd16", 32'(bcd16), 32'd0);
    check("rst_busy16", 32'(busy16), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      exp8 = SIGNED_MODE ? vecs[i].bcd_s : vecs[i].bcd_u;
      exps = SIGNED_MODE ? vecs[i].sign_s : 1'b0;
      conv8(vecs[i].bin, lat, bn);
      $display("vec %0d: bin=%0d bcd=%03h sign=%0b lat=%0d busy=%0d", i, vecs[i].bin, bcd8, sign8, lat, bn);
      check("vec_bcd",  32'(bcd8),  32'(exp8));
      check("vec_sign", 32'(sign8), 32'(exps));
      check("vec_lat",  32'(lat),   32'd17);
      check("vec_busy_cycles", 32'(bn), 32'd17);
      @(negedge clk);
      check("vec_dv_one_cycle", 32'(dv8),   32'd0);
      check("vec_busy_after",   32'(busy8), 32'd0);
      repeat (3) @(negedge clk);
      check("vec_bcd_hold", 32'(bcd8), 32'(exp8));
    end

    // Start pulsed during a conversion must be ignored
    @(negedge clk);
    bin8   = 8'd255;
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    bin8   = 8'd7;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dv_n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (dv8) dv_n++;
    end
    $display("ignore: dv_count=%0d bcd=%03h", dv_n, bcd8);
    check("ignore_dv_count", 32'(dv_n), 32'd1);
    check("ignore_bcd", 32'(bcd8), SIGNED_MODE ? 32'h001 : 32'h255);

    // Reset in the middle of a conversion
    @(negedge clk);
    bin8   = 8'd200;
    start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_dv",   32'(dv8),   32'd0);
    check("midrst_bcd",  32'(bcd8),  32'd0);
    check("midrst_sign", 32'(sign8), 32'd0);
    dv_n = 0;
    repeat (2) begin
      @(negedge clk);
      if (dv8) dv_n++;
    end
    @(posedge clk);
    #2 rst = 1'b0;
    conv8(8'd128, lat, bn);
    $display("after_rst: bin=128 bcd=%03h lat=%0d", bcd8, lat);
    check("midrst_no_dv", 32'(dv_n), 32'd0);
    check("after_rst_bcd", 32'(bcd8), 32'h128);
    check("after_rst_lat", 32'(lat), 32'd17);

    // 16-bit instance: single conversion, then start held high
    conv16(16'd65535, lat);
    $display("w16: bin=65535 bcd=%05h sign=%0b lat=%0d", bcd16, sign16, lat);
    check("w16_bcd",  32'(bcd16),  SIGNED_MODE ? 32'h00001 : 32'h65535);
    check("w16_sign", 32'(sign16), SIGNED_MODE ? 32'd1 : 32'd0);
    check("w16_lat",  32'(lat),    32'd33);

    @(negedge clk);
    bin16   = 16'd1234;
    start16 = 1'b1;
    lat = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dv16) begin
        lat = k + 1;
        break;
      end
    end
    gap = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dv16) begin
        gap = k + 1;
        break;
      end
    end
    start16 = 1'b0;
    $display("w16_held: bin=1234 bcd=%05h first_lat=%0d gap=%0d", bcd16, lat, gap);
    check("w16_held_lat", 32'(lat), 32'd33);
    check("w16_held_gap", 32'(gap), 32'd34);
    check("w16_held_bcd", 32'(bcd16), 32'h01234);

    repeat (40) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
